// File: rtl/stage3_integrator_part.sv
// Trapezoidal filter reconstruction: pole-zero correction, double accumulation,
// scaling and saturation, with a warm-up gate on the output ready flag.
module stage3_integrator_part #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned M_COEF    = 0,
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned WARMUP    = 744
) (
    input  logic                     SYS_CLK,
    input  logic                     RESET_N,
    input  logic signed [DATA_W-1:0] DATA_IN,
    input  logic                     DATA_VALID,
    input  logic                     CLEAR,
    output logic signed [DATA_W-1:0] DATAOUT,
    output logic                     OUT_VALID,
    output logic                     OUT_READY
);

    localparam int unsigned CNT_W = $clog2(WARMUP + 1);
    localparam int unsigned EXT_W = ACC_W - DATA_W;

    localparam logic signed [ACC_W-1:0] M_S     = ACC_W'(M_COEF);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic        [CNT_W-1:0]   r_cnt;
    logic        [CNT_W-1:0]   w_cnt_nxt;
    logic        [CNT_W-1:0]   w_cnt_inc;
    logic                      w_accept;
    logic                      w_rdy_tag;

    logic signed [ACC_W-1:0]   r_p;
    logic signed [DATA_W-1:0]  r_dq;
    logic                      r_va;
    logic                      r_ra;
    logic signed [ACC_W-1:0]   r_r;
    logic                      r_vb;
    logic                      r_rb;
    logic signed [ACC_W-1:0]   r_s;
    logic                      r_vc;
    logic                      r_rc;

    logic signed [ACC_W-1:0]   w_din_ext;
    logic signed [ACC_W-1:0]   w_dq_ext;
    logic signed [ACC_W-1:0]   w_corr;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [DATA_W-1:0]  w_sat;

    // A sample entering while CLEAR is high is dropped along with the flush.
    assign w_accept  = DATA_VALID & ~CLEAR;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    assign w_din_ext = {{EXT_W{DATA_IN[DATA_W-1]}}, DATA_IN};
    assign w_dq_ext  = {{EXT_W{r_dq[DATA_W-1]}}, r_dq};
    assign w_corr    = M_S * w_dq_ext;
    assign w_shift   = r_s >>> OUT_SHIFT;

    // Clamp the scaled accumulator into the output range.
    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Warm-up FSM; w_rdy_tag marks the sample that travels with OUT_READY=1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdy_tag   = 1'b0;
        if (CLEAR) begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(WARMUP)) begin
                            w_state_nxt = RUN;
                            w_rdy_tag   = 1'b1;
                        end
                    end
                end
                RUN: begin
                    w_rdy_tag = 1'b1;
                end
                default: begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Stage A: first integrator plus delayed delta for the correction term.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_p  <= '0;
            r_dq <= '0;
            r_va <= 1'b0;
            r_ra <= 1'b0;
        end else if (CLEAR) begin
            r_p  <= '0;
            r_va <= 1'b0;
            r_ra <= 1'b0;
        end else begin
            r_va <= w_accept;
            r_ra <= w_rdy_tag;
            if (w_accept) begin
                r_p  <= r_p + w_din_ext;
                r_dq <= DATA_IN;
            end
        end
    end

    // Stage B: pole-zero corrected sample.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_r  <= '0;
            r_vb <= 1'b0;
            r_rb <= 1'b0;
        end else if (CLEAR) begin
            r_r  <= '0;
            r_vb <= 1'b0;
            r_rb <= 1'b0;
        end else begin
            r_vb <= r_va;
            r_rb <= r_ra;
            if (r_va) begin
                r_r <= r_p + w_corr;
            end
        end
    end

    // Stage C: second integrator.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s  <= '0;
            r_vc <= 1'b0;
            r_rc <= 1'b0;
        end else if (CLEAR) begin
            r_s  <= '0;
            r_vc <= 1'b0;
            r_rc <= 1'b0;
        end else begin
            r_vc <= r_vb;
            r_rc <= r_rb;
            if (r_vb) begin
                r_s <= r_s + r_r;
            end
        end
    end

    // Stage D: registered outputs; DATAOUT and OUT_READY hold between pulses.
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DATAOUT   <= '0;
            OUT_VALID <= 1'b0;
            OUT_READY <= 1'b0;
        end else if (CLEAR) begin
            DATAOUT   <= '0;
            OUT_VALID <= 1'b0;
            OUT_READY <= 1'b0;
        end else begin
            OUT_VALID <= r_vc;
            if (r_vc) begin
                DATAOUT   <= w_sat;
                OUT_READY <= r_rc;
            end
        end
    end

endmodule

// File: tb/tb_stage3_integrator_part.sv
// Directed bench for stage3_integrator_part: three parameterisations share one
// stimulus stream; a per-instance model fills scoreboard queues checked on output.
module tb_stage3_integrator_part;

    localparam int NDUT = 3;
    localparam int WU   = 4;

    typedef struct {
        logic signed [63:0] data;
        logic               rdy;
        longint             due;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic signed [31:0] din;
    logic               dv;
    logic               clr;
    logic signed [31:0] dout [NDUT];
    logic               oval [NDUT];
    logic               ordy [NDUT];

    exp_t               q [NDUT][$];
    longint             mp [NDUT];
    longint             ms [NDUT];
    int                 mcnt [NDUT];
    logic signed [63:0] last_d [NDUT];
    logic               last_r [NDUT];
    longint             cyc;
    int                 n_checks;
    int                 n_errors;

    stage3_integrator_part #(.DATA_W(32), .ACC_W(48), .M_COEF(0), .OUT_SHIFT(0), .WARMUP(WU)) u_dut0 (
        .SYS_CLK(clk), .RESET_N(rst_n), .DATA_IN(din), .DATA_VALID(dv), .CLEAR(clr),
        .DATAOUT(dout[0]), .OUT_VALID(oval[0]), .OUT_READY(ordy[0]));

    stage3_integrator_part #(.DATA_W(32), .ACC_W(48), .M_COEF(3), .OUT_SHIFT(0), .WARMUP(WU)) u_dut1 (
        .SYS_CLK(clk), .RESET_N(rst_n), .DATA_IN(din), .DATA_VALID(dv), .CLEAR(clr),
        .DATAOUT(dout[1]), .OUT_VALID(oval[1]), .OUT_READY(ordy[1]));

    stage3_integrator_part #(.DATA_W(32), .ACC_W(48), .M_COEF(0), .OUT_SHIFT(2), .WARMUP(WU)) u_dut2 (
        .SYS_CLK(clk), .RESET_N(rst_n), .DATA_IN(din), .DATA_VALID(dv), .CLEAR(clr),
        .DATAOUT(dout[2]), .OUT_VALID(oval[2]), .OUT_READY(ordy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint mcoef(int i);
        return (i == 1) ? 64'sd3 : 64'sd0;
    endfunction

    function automatic int oshift(int i);
        return (i == 2) ? 2 : 0;
    endfunction

    function automatic longint satf(longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            mp[i]   = 0;
            ms[i]   = 0;
            mcnt[i] = 0;
        end
    endtask

    task automatic model_accept(longint d);
        longint r;
        exp_t   e;
        for (int i = 0; i < NDUT; i++) begin
            mp[i]   = mp[i] + d;
            r       = mp[i] + mcoef(i) * d;
            ms[i]   = ms[i] + r;
            mcnt[i] = mcnt[i] + 1;
            e.data  = satf(ms[i] >>> oshift(i));
            e.rdy   = (mcnt[i] >= WU);
            e.due   = cyc + 4;
            q[i].push_back(e);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, then advance.
    task automatic step(bit v, longint d, bit c);
        dv  = v;
        din = 32'(d);
        clr = c;
        if (c) model_reset();
        else if (v) model_accept(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0);
    endtask

    // Monitor on the falling edge: expected pulse when due, otherwise outputs hold.
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (q[i].size() > 0 && q[i][0].due <= cyc) begin
                exp_t e;
                e = q[i].pop_front();
                chk($sformatf("dut%0d out_valid", i), 64'(oval[i]), 64'd1);
                chk($sformatf("dut%0d dataout", i), 64'(dout[i]), e.data);
                chk($sformatf("dut%0d out_ready", i), 64'(ordy[i]), 64'(e.rdy));
                last_d[i] = e.data;
                last_r[i] = e.rdy;
            end else begin
                chk($sformatf("dut%0d idle out_valid", i), 64'(oval[i]), 64'd0);
                chk($sformatf("dut%0d hold dataout", i), 64'(dout[i]), last_d[i]);
                chk($sformatf("dut%0d hold out_ready", i), 64'(ordy[i]), 64'(last_r[i]));
            end
            if (clr === 1'b1 && rst_n === 1'b1) begin
                q[i].delete();
                last_d[i] = 0;
                last_r[i] = 1'b0;
            end
        end
    end

    task automatic flush_for_reset();
        model_reset();
        for (int i = 0; i < NDUT; i++) begin
            q[i].delete();
            last_d[i] = 0;
            last_r[i] = 1'b0;
        end
    endtask

    task automatic chk_zero(string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("%s dut%0d dataout", tag, i), 64'(dout[i]), 64'd0);
            chk($sformatf("%s dut%0d out_valid", tag, i), 64'(oval[i]), 64'd0);
            chk($sformatf("%s dut%0d out_ready", tag, i), 64'(ordy[i]), 64'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        dv       = 1'b0;
        clr      = 1'b0;
        din      = '0;
        flush_for_reset();

        // Reset state
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Impulse of 1 then continuous zeros
        step(1'b1, 1, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b1, 0, 1'b0);
        idle(5);

        // Impulse of -2 after a flush
        step(1'b0, 0, 1'b1);
        step(1'b1, -2, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 0, 1'b0);
        idle(5);

        // Positive saturation, then negative mirror
        step(1'b0, 0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, 64'sd1073741824, 1'b0);
        idle(5);
        step(1'b0, 0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b1, -64'sd1073741824, 1'b0);
        idle(5);

        // Warm-up with gaps in DATA_VALID, then idle hold
        step(1'b0, 0, 1'b1);
        step(1'b1, 5, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b1, -3, 1'b0);
        step(1'b1, 7, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b1, 2, 1'b0);
        idle(7);

        // CLEAR coincident with DATA_VALID while samples are in flight
        step(1'b1, 11, 1'b0);
        step(1'b1, 13, 1'b0);
        step(1'b1, 9, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 64'(k + 1), 1'b0);
        idle(5);

        // Asynchronous reset between edges while streaming
        step(1'b1, 1, 1'b0);
        step(1'b1, 2, 1'b0);
        dv = 1'b1;
        din = 32'sd3;
        #3;
        rst_n = 1'b0;
        flush_for_reset();
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #1;
        chk_zero("held reset");
        rst_n = 1'b1;
        step(1'b1, 1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 0, 1'b0);
        idle(6);

        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("dut%0d scoreboard drained", i), 64'(q[i].size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stage3_integrator_part.md
Name: stage3_integrator_part

Overview:
- Reconstruction half of the trapezoidal filter chain. Consumes the delta stream produced by the stage-2 comb (x[n] - x[n-k] - x[n-l] + x[n-k-l] form) and produces the trapezoid-shaped output.
- Performs pole-zero correction and a double accumulation: p[n] = p[n-1] + d[n], r[n] = p[n] + M*d[n], s[n] = s[n-1] + r[n].
- Scales and saturates the result, and gates a ready flag until the delay lines upstream have filled.

Parameters:
- DATA_W, 32, width of signed input delta and signed output.
- ACC_W, 48, width of signed internal accumulators p, r, s.
- M_COEF, 0, unsigned pole-zero correction multiplier, range 0..65535.
- OUT_SHIFT, 0, arithmetic right shift applied to s before saturation, range 0..ACC_W-DATA_W.
- WARMUP, 744, number of accepted samples before OUT_READY asserts, minimum 1.

Ports:
- SYS_CLK, input, 1, system clock; all state changes on its rising edge.
- RESET_N, input, 1, asynchronous active-low reset.
- DATA_IN, input, DATA_W, signed delta sample from the stage-2 comb.
- DATA_VALID, input, 1, DATA_IN is accepted on a rising edge while this is high.
- CLEAR, input, 1, synchronous flush of accumulators and warm-up counter.
- DATAOUT, output, DATA_W, signed filtered output, registered.
- OUT_VALID, output, 1, DATAOUT updated this cycle; high for one cycle per accepted sample.
- OUT_READY, output, 1, warm-up complete; DATAOUT is meaningful.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - p, d_q, r, s, DATAOUT cleared to 0.
  - All pipeline valid flags cleared to 0; OUT_VALID = 0, OUT_READY = 0.
  - Warm-up counter cleared to 0; FSM forced to FILL.
- Asserting reset mid-operation discards all in-flight samples. No output activity until new samples are accepted after release.
- Pipeline (each stage advances every cycle; each stage's registers update only when that stage's valid flag is set):
  - Stage A, edge t, sample accepted: p <= p + sext(DATA_IN); d_q <= DATA_IN; va <= 1. Otherwise va <= 0.
  - Stage B, edge t+1, if va: r <= p + M_COEF*sext(d_q), using the updated p. vb <= va.
  - Stage C, edge t+2, if vb: s <= s + r. vc <= vb.
  - Stage D, edge t+3, if vc: DATAOUT <= sat(s >>> OUT_SHIFT). OUT_VALID <= vc.
  - Latency is 4 rising edges from acceptance to OUT_VALID high. Throughput is one sample per clock.
  - Gaps in DATA_VALID hold p, r, s and DATAOUT unchanged.
- Arithmetic:
  - All accumulation is signed two's complement at ACC_W and wraps modulo 2^ACC_W internally. No internal saturation; ACC_W must be sized by the integrator.
  - sat(): clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FSM, two states:
  - FILL: the warm-up counter increments on each accepted sample. When the accepted sample brings the count to WARMUP, the FSM moves to RUN.
  - RUN: the counter holds.
  - OUT_READY = 1 only in RUN, asserted in the same cycle as OUT_VALID for sample number WARMUP, i.e. aligned through the pipeline.
- CLEAR (synchronous, highest priority after reset):
  - On an edge with CLEAR = 1: p, r, s, DATAOUT <= 0; all valid flags <= 0; counter <= 0; FSM <= FILL; OUT_READY <= 0.
  - A DATA_VALID in the same cycle is dropped.
  - In-flight samples are dropped and produce no OUT_VALID.
- DATAOUT holds its last value between OUT_VALID pulses.

Test Plan:
- Impulse, M_COEF=0, OUT_SHIFT=0: DATA_IN=1 once, then 0 with DATA_VALID=1 continuous -> OUT_VALID starts 4 cycles after the first sample; DATAOUT = 1, 2, 3, 4, ...
- Pole-zero correction, M_COEF=3: impulse of 1 then zeros -> DATAOUT = 4, 5, 6, 7. Impulse of -2 -> -8, -10, -12.
- Saturation, OUT_SHIFT=0: DATA_IN = 2^30 on every cycle -> DATAOUT = 2^30, then sticks at 2147483647. Negative mirror sticks at -2147483648.
- Warm-up, WARMUP=4, with DATA_VALID gaps (1,0,1,1,0,1): OUT_READY rises with the 4th OUT_VALID, not before. It stays high over idle cycles, and DATAOUT holds.
- CLEAR mid-stream, coincident with DATA_VALID=1: the next OUT_VALID appears only for samples accepted after CLEAR. Accumulation restarts from 0 and OUT_READY = 0 until 4 more samples.
- RESET_N pulsed low asynchronously between clock edges during streaming: all outputs go to 0 immediately. After release, the impulse test reproduces 1, 2, 3, ...
